// File: rtl/mips_core_pkg.sv
// Shared decode/issue types: physical register tags and the renamed instruction
// record carried from rename through the issue buffer.
package mips_core_pkg;

    localparam int PHYS_REG_W = 6;

    typedef logic [PHYS_REG_W-1:0] phys_reg_t;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_action_t;

    typedef struct packed {
        phys_reg_t   phys_rs;
        phys_reg_t   phys_rt;
        logic [3:0]  alu_ctl;
        logic        uses_rs;
        logic        uses_rt;
        logic        uses_immediate;
        logic [31:0] immediate;
        logic        is_branch;
        logic        prediction;
        logic [31:0] recovery_target;
        logic        is_mem_access;
        mem_action_t mem_action;
        logic [5:0]  active_list_id;
    } issue_entry_t;

endpackage

// File: rtl/issue_wakeup_match.sv
// Compares one source tag against every live writeback broadcast.
module issue_wakeup_match
    import mips_core_pkg::*;
#(
    parameter int WB_PORTS = 2
) (
    input  phys_reg_t                  tag,
    input  logic      [WB_PORTS-1:0]   wb_valid,
    input  phys_reg_t [WB_PORTS-1:0]   wb_tag,
    output logic                       hit
);

    always_comb begin
        hit = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p] && (wb_tag[p] == tag)) hit = 1'b1;
        end
    end

endmodule

// File: rtl/decode_issue_buffer.sv
// In-order circular buffer between rename and issue with per-entry operand
// wakeup; head entries are presented with same-cycle wakeup folded in.
module decode_issue_buffer
    import mips_core_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int ENQ_WIDTH   = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int WB_PORTS    = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic         [ENQ_WIDTH-1:0]         in_valid,
    input  issue_entry_t [ENQ_WIDTH-1:0]         in_entry,
    input  logic         [ENQ_WIDTH-1:0]         in_rs_ready,
    input  logic         [ENQ_WIDTH-1:0]         in_rt_ready,
    output logic                                 in_ready,
    input  logic         [WB_PORTS-1:0]          wb_valid,
    input  phys_reg_t    [WB_PORTS-1:0]          wb_tag,
    output logic         [ISSUE_WIDTH-1:0]       out_valid,
    output issue_entry_t [ISSUE_WIDTH-1:0]       out_entry,
    output logic         [ISSUE_WIDTH-1:0]       out_rs_ready,
    output logic         [ISSUE_WIDTH-1:0]       out_rt_ready,
    input  logic [$clog2(ISSUE_WIDTH+1)-1:0]     out_take,
    input  logic                                 flush,
    output logic [$clog2(DEPTH+1)-1:0]           count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = $clog2(ISSUE_WIDTH+1);

    issue_entry_t        mem [DEPTH];
    logic [DEPTH-1:0]    rs_rdy, rt_rdy, ent_rs_hit, ent_rt_hit, occ;
    logic [ENQ_WIDTH-1:0] in_rs_hit, in_rt_hit;
    logic [PW-1:0]       head, tail;
    logic [WB_PORTS-1:0] wb_live;
    logic [TW-1:0]       avail, deq;
    logic [CW-1:0]       enq;

    // Broadcasts in a flush cycle belong to squashed work and must not wake anything.
    assign wb_live  = flush ? '0 : wb_valid;
    assign in_ready = (CW'(DEPTH) - count) >= CW'(ENQ_WIDTH);
    assign enq      = in_ready ? CW'($countones(in_valid)) : '0;
    assign avail    = (count >= CW'(ISSUE_WIDTH)) ? TW'(ISSUE_WIDTH) : TW'(count);
    assign deq      = (out_take > avail) ? avail : out_take;

    for (genvar j = 0; j < DEPTH; j++) begin : g_ent
        assign occ[j] = {1'b0, PW'(j) - head} < count;
        issue_wakeup_match #(.WB_PORTS(WB_PORTS)) u_rs (
            .tag(mem[j].phys_rs), .wb_valid(wb_live), .wb_tag(wb_tag), .hit(ent_rs_hit[j]));
        issue_wakeup_match #(.WB_PORTS(WB_PORTS)) u_rt (
            .tag(mem[j].phys_rt), .wb_valid(wb_live), .wb_tag(wb_tag), .hit(ent_rt_hit[j]));
    end

    for (genvar i = 0; i < ENQ_WIDTH; i++) begin : g_in
        issue_wakeup_match #(.WB_PORTS(WB_PORTS)) u_rs (
            .tag(in_entry[i].phys_rs), .wb_valid(wb_live), .wb_tag(wb_tag), .hit(in_rs_hit[i]));
        issue_wakeup_match #(.WB_PORTS(WB_PORTS)) u_rt (
            .tag(in_entry[i].phys_rt), .wb_valid(wb_live), .wb_tag(wb_tag), .hit(in_rt_hit[i]));
    end

    for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_out
        logic [PW-1:0] idx;
        assign idx             = head + PW'(k);
        assign out_valid[k]    = count > CW'(k);
        assign out_entry[k]    = out_valid[k] ? mem[idx] : '0;
        assign out_rs_ready[k] = out_valid[k] & (rs_rdy[idx] | ent_rs_hit[idx]);
        assign out_rt_ready[k] = out_valid[k] & (rt_rdy[idx] | ent_rt_hit[idx]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            rs_rdy <= '0;
            rt_rdy <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head   <= head + PW'(deq);
            tail   <= tail + PW'(enq);
            count  <= count + enq - CW'(deq);
            rs_rdy <= rs_rdy | (ent_rs_hit & occ);
            rt_rdy <= rt_rdy | (ent_rt_hit & occ);
            // Incoming slots overwrite the bits of the (free) slots they land in.
            for (int i = 0; i < ENQ_WIDTH; i++) begin
                if (in_ready && in_valid[i]) begin
                    rs_rdy[tail + PW'(i)] <= in_rs_ready[i] | ~in_entry[i].uses_rs | in_rs_hit[i];
                    rt_rdy[tail + PW'(i)] <= in_rt_ready[i] | ~in_entry[i].uses_rt | in_rt_hit[i];
                end
            end
        end
    end

    // Payload storage needs no reset; occupancy is governed by count.
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int i = 0; i < ENQ_WIDTH; i++) begin
                if (in_ready && in_valid[i]) mem[tail + PW'(i)] <= in_entry[i];
            end
        end
    end

    a_take_legal: assert property (@(posedge clk) disable iff (!rst_n) out_take <= avail);

endmodule
